uart_param: RTL

Parametrised, runtime-configurable UART: the successor to the team's fixed 8N1 UART. It adds configurable data width, a runtime baud divisor, optional even/odd parity, configurable stop length, FIFO depth as a parameter, and per-byte parity/framing error reporting plus a sticky overrun flag. It sits between the board serial pins and the core's byte-level host logic, with the same `rd_uart`/`wr_uart` FIFO handshake as the existing UART.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_param_if.sv | 31 +++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART.
//   uart_state_e : FSM state encoding used by both the RX and TX machines.
//   START_MID    : tick index at which the start bit is re-sampled (mid-bit).
//   BIT_TICKS    : oversample ticks per data/start/parity bit.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int START_MID = 7;
  localparam int BIT_TICKS = 16;
endpackage

// File: rtl/uart_param_if.sv
// uart_param_if: host-side byte interface of uart_param.
//   master (host) drives : dvsr, par_en, par_odd, rd_uart, wr_uart, w_data, clr_ovr
//   slave  (uart) drives : tx_full, rx_empty, r_data, parity_err, frame_err, overrun_err
interface uart_param_if #(
  parameter int DBIT   = 8,
  parameter int DVSR_W = 11
);
  logic [DVSR_W-1:0] dvsr;
  logic              par_en;
  logic              par_odd;
  logic              rd_uart;
  logic              wr_uart;
  logic [DBIT-1:0]   w_data;
  logic              clr_ovr;
  logic              tx_full;
  logic              rx_empty;
  logic [DBIT-1:0]   r_data;
  logic              parity_err;
  logic              frame_err;
  logic              overrun_err;

  modport master (
    output dvsr, par_en, par_odd, rd_uart, wr_uart, w_data, clr_ovr,
    input  tx_full, rx_empty, r_data, parity_err, frame_err, overrun_err
  );

  modport slave (
    input  dvsr, par_en, par_odd, rd_uart, wr_uart, w_data, clr_ovr,
    output tx_full, rx_empty, r_data, parity_err, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: first-word fall-through FIFO, 2^FIFO_W entries of W bits.
//   clk, reset : clock, synchronous active-high reset
//   i_wr/i_wdata : push (ignored when full unless a pop happens the same cycle)
//   i_rd         : pop (ignored when empty)
//   o_rdata      : head entry, forced to 0 while empty
//   o_full/o_empty : occupancy flags
module uart_fifo #(
  parameter int W      = 8,
  parameter int FIFO_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int DEPTH = 1 << FIFO_W;

  logic [W-1:0]      r_mem [DEPTH];
  logic [FIFO_W-1:0] r_wptr, r_rptr;
  logic [FIFO_W:0]   r_cnt;
  logic              w_do_rd, w_do_wr;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (FIFO_W+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/uart_param.sv
// uart_param: runtime-configurable UART (5-9 data bits, optional even/odd
// parity, SB_TICK-tick stop, baud divisor input) with TX/RX FIFOs.
//   clk, reset : clock, synchronous active-high reset
//   rx, tx     : serial pins, idle high
//   bus        : host byte interface (divisor/parity config, FIFO handshake,
//                per-entry parity/framing flags, sticky overrun)
module uart_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 2,
  parameter int DVSR_W  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  uart_param_if.slave bus
);
  localparam int SW = (SB_TICK > BIT_TICKS) ? $clog2(SB_TICK) : $clog2(BIT_TICKS);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(START_MID);
  localparam logic [SW-1:0] S_BIT  = SW'(BIT_TICKS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  // ---------------- baud generator ----------------
  // Divisor is latched at each wrap so a new value never truncates a period.
  logic [DVSR_W-1:0] r_baud_cnt, r_dvsr;
  logic              w_tick;

  assign w_tick = (r_baud_cnt == r_dvsr);

  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_baud_cnt <= '0;
      r_dvsr     <= bus.dvsr;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  // ---------------- RX ----------------
  logic [1:0]      r_rx_sync;
  logic            w_rxd;
  uart_state_e     r_rx_state, w_rx_state;
  logic [SW-1:0]   r_rx_s, w_rx_s;
  logic [NW-1:0]   r_rx_n, w_rx_n;
  logic [DBIT-1:0] r_rx_b, w_rx_b;
  logic            r_rx_perr, w_rx_perr;
  logic            w_rx_done, w_rx_ferr, w_rx_push, w_rx_full, w_rx_empty;
  logic [DBIT+1:0] w_rx_head;
  logic            r_ovr;

  assign w_rxd = r_rx_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= IDLE;
      r_rx_s     <= '0;
      r_rx_n     <= '0;
      r_rx_b     <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], rx};
      r_rx_state <= w_rx_state;
      r_rx_s     <= w_rx_s;
      r_rx_n     <= w_rx_n;
      r_rx_b     <= w_rx_b;
      r_rx_perr  <= w_rx_perr;
    end
  end

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_s     = r_rx_s;
    w_rx_n     = r_rx_n;
    w_rx_b     = r_rx_b;
    w_rx_perr  = r_rx_perr;
    w_rx_done  = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_state)
      IDLE: if (!w_rxd) begin
        w_rx_state = START;
        w_rx_s     = '0;
      end
      START: if (w_tick) begin
        if (r_rx_s == S_MID) begin
          // Still low at mid start bit: real frame; otherwise a glitch.
          if (!w_rxd) begin
            w_rx_state = DATA;
            w_rx_s     = '0;
            w_rx_n     = '0;
            w_rx_perr  = 1'b0;
          end else begin
            w_rx_state = IDLE;
          end
        end else w_rx_s = r_rx_s + 1'b1;
      end
      DATA: if (w_tick) begin
        if (r_rx_s == S_BIT) begin
          w_rx_s = '0;
          w_rx_b = {w_rxd, r_rx_b[DBIT-1:1]};
          if (r_rx_n == N_LAST) w_rx_state = bus.par_en ? PARITY : STOP;
          else                  w_rx_n     = r_rx_n + 1'b1;
        end else w_rx_s = r_rx_s + 1'b1;
      end
      PARITY: if (w_tick) begin
        if (r_rx_s == S_BIT) begin
          w_rx_s     = '0;
          w_rx_perr  = (^r_rx_b) ^ w_rxd ^ bus.par_odd;
          w_rx_state = STOP;
        end else w_rx_s = r_rx_s + 1'b1;
      end
      STOP: if (w_tick) begin
        if (r_rx_s == S_STOP) begin
          w_rx_done  = 1'b1;
          w_rx_ferr  = ~w_rxd;
          w_rx_state = IDLE;
        end else w_rx_s = r_rx_s + 1'b1;
      end
      default: w_rx_state = IDLE;
    endcase
  end

  // A completed frame meeting a full FIFO is dropped, even if the host pops that cycle.
  assign w_rx_push = w_rx_done & ~w_rx_full;

  uart_fifo #(.W(DBIT+2), .FIFO_W(FIFO_W)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_rx_push),
    .i_rd    (bus.rd_uart),
    .i_wdata ({w_rx_ferr, r_rx_perr, r_rx_b}),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Set has priority over clear so a same-cycle overrun is never lost.
  always_ff @(posedge clk) begin
    if (reset) r_ovr <= 1'b0;
    else       r_ovr <= (r_ovr & ~bus.clr_ovr) | (w_rx_done & w_rx_full);
  end

  assign {bus.frame_err, bus.parity_err, bus.r_data} = w_rx_head;
  assign bus.rx_empty    = w_rx_empty;
  assign bus.overrun_err = r_ovr;

  // ---------------- TX ----------------
  uart_state_e     r_tx_state, w_tx_state;
  logic [SW-1:0]   r_tx_s, w_tx_s;
  logic [NW-1:0]   r_tx_n, w_tx_n;
  logic [DBIT-1:0] r_tx_b, w_tx_b;
  logic            r_tx_par, w_tx_par;
  logic            r_tx, w_tx;
  logic            w_tx_pop, w_tx_full, w_tx_empty;
  logic [DBIT-1:0] w_tx_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_s     <= w_tx_s;
      r_tx_n     <= w_tx_n;
      r_tx_b     <= w_tx_b;
      r_tx_par   <= w_tx_par;
      r_tx       <= w_tx;
    end
  end

  // The line register follows the state by one cycle uniformly, so all bits keep equal length.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_s     = r_tx_s;
    w_tx_n     = r_tx_n;
    w_tx_b     = r_tx_b;
    w_tx_par   = r_tx_par;
    w_tx       = r_tx;
    w_tx_pop   = 1'b0;
    case (r_tx_state)
      IDLE: begin
        w_tx = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop   = 1'b1;
          w_tx_b     = w_tx_head;
          w_tx_par   = (^w_tx_head) ^ bus.par_odd;
          w_tx_s     = '0;
          w_tx_state = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_tick) begin
          if (r_tx_s == S_BIT) begin
            w_tx_s     = '0;
            w_tx_n     = '0;
            w_tx_state = DATA;
          end else w_tx_s = r_tx_s + 1'b1;
        end
      end
      DATA: begin
        w_tx = r_tx_b[0];
        if (w_tick) begin
          if (r_tx_s == S_BIT) begin
            w_tx_s = '0;
            w_tx_b = r_tx_b >> 1;
            if (r_tx_n == N_LAST) w_tx_state = bus.par_en ? PARITY : STOP;
            else                  w_tx_n     = r_tx_n + 1'b1;
          end else w_tx_s = r_tx_s + 1'b1;
        end
      end
      PARITY: begin
        w_tx = r_tx_par;
        if (w_tick) begin
          if (r_tx_s == S_BIT) begin
            w_tx_s     = '0;
            w_tx_state = STOP;
          end else w_tx_s = r_tx_s + 1'b1;
        end
      end
      STOP: begin
        w_tx = 1'b1;
        if (w_tick) begin
          if (r_tx_s == S_STOP) w_tx_state = IDLE;
          else                  w_tx_s     = r_tx_s + 1'b1;
        end
      end
      default: w_tx_state = IDLE;
    endcase
  end

  uart_fifo #(.W(DBIT), .FIFO_W(FIFO_W)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (bus.wr_uart),
    .i_rd    (w_tx_pop),
    .i_wdata (bus.w_data),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign bus.tx_full = w_tx_full;
  assign tx          = r_tx;
endmodule
